scan_muxer: RTL and testbench

SCAN_MUXER -- requirements
Module: scan_muxer

---
 rtl/scan_muxer_pkg.sv | 20 ++
 rtl/scan_next_ch.sv | 27 ++
 rtl/scan_muxer.sv | 103 ++++++++++
 tb/tb_scan_muxer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/scan_muxer_pkg.sv
// Shared definitions for scan_muxer: the mode encodings and modulo-N index helpers.
// The helpers take N as an argument so that any channel count can use them.
package scan_muxer_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Next index after idx, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

  // (base + off) mod n. Only valid when base < n and off < n.
  function automatic int rot_idx(input int base, input int off, input int n);
    int k;
    k = base + off;
    return (k >= n) ? k - n : k;
  endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Rotating first-set search: finds the first set bit of vec, looking upward from start
// and wrapping past N-1. Returns that bit's index, and found=0 when vec is all zeros.
module scan_next_ch
  import scan_muxer_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  input  logic [SW-1:0] start,
  output logic [SW-1:0] idx,
  output logic          found
);

  // The loop counts downward, so the match closest to start is written last and wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[rot_idx(int'(start), i, N)]) begin
        idx   = SW'(rot_idx(int'(start), i, N));
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scan_muxer.sv
// Registered N-to-1 channel muxer. It has a direct-select mode and a round-robin scan mode.
// Building with SCAN_MUXER_MASK_EN adds a mask port, and scan mode then skips disabled channels.
module scan_muxer
  import scan_muxer_pkg::*;
#(
  parameter int  N  = 4,
  parameter int  W  = 1,
  localparam int SW = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N*W-1:0]  x,
  input  logic [SW-1:0]   b,
  input  logic            mode,
  input  logic            en,
`ifdef SCAN_MUXER_MASK_EN
  input  logic [N-1:0]    mask,
`endif
  output logic [W-1:0]    z,
  output logic [SW-1:0]   ch,
  output logic            valid
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_nxt;
  logic [SW-1:0] samp_ch;
  logic [SW-1:0] sel_ch;
  logic          samp_ok;
  logic          b_in_range;
  logic [W-1:0]  samp_data;

  // Widen b by one bit so that the range compare also holds when N is a power of two.
  assign b_in_range = ({1'b0, b} < (SW + 1)'(N));

`ifdef SCAN_MUXER_MASK_EN
  logic [SW-1:0] hit_idx;
  logic [SW-1:0] adv_idx;
  logic [SW-1:0] adv_start;
  logic          hit_found;
  logic          adv_found;

  scan_next_ch #(.N(N), .SW(SW)) u_hit (
    .vec   (mask),
    .start (ptr),
    .idx   (hit_idx),
    .found (hit_found)
  );

  // The pointer moves past the channel just sampled, to the next enabled channel.
  assign adv_start = SW'(wrap_inc(int'(hit_idx), N));

  scan_next_ch #(.N(N), .SW(SW)) u_adv (
    .vec   (mask),
    .start (adv_start),
    .idx   (adv_idx),
    .found (adv_found)
  );
`endif

  always_comb begin
    samp_ok = 1'b0;
    samp_ch = ptr;
    ptr_nxt = ptr;
    if (mode == MODE_DIRECT) begin
      samp_ok = b_in_range;
      samp_ch = b;
    end else begin
`ifdef SCAN_MUXER_MASK_EN
      samp_ok = hit_found;
      samp_ch = hit_idx;
      ptr_nxt = hit_found ? (adv_found ? adv_idx : hit_idx) : ptr;
`else
      samp_ok = 1'b1;
      samp_ch = ptr;
      ptr_nxt = SW'(wrap_inc(int'(ptr), N));
`endif
    end
  end

  // Clamp the select so the part-select never reaches past x on a dropped direct sample.
  assign sel_ch    = samp_ok ? samp_ch : '0;
  assign samp_data = x[int'(sel_ch)*W +: W];

  always_ff @(posedge clock) begin
    if (reset) begin
      z     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else begin
      valid <= 1'b0;
      if (en && samp_ok) begin
        z     <= samp_data;
        ch    <= samp_ch;
        valid <= 1'b1;
        if (mode == MODE_SCAN) begin
          ptr <= ptr_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_muxer.sv
// Directed bench for scan_muxer. It drives an N=4/W=8 instance and an N=3/W=4 instance,
// and checks their outputs against hand-computed values.
module tb_scan_muxer;
  import scan_muxer_pkg::*;

  logic        clock = 1'b0;
  logic        reset;

  logic [31:0] x4;
  logic [1:0]  b4;
  logic        mode4, en4;
  logic [7:0]  z4;
  logic [1:0]  ch4;
  logic        v4;

  logic [11:0] x3;
  logic [1:0]  b3;
  logic        mode3, en3;
  logic [3:0]  z3;
  logic [1:0]  ch3;
  logic        v3;

`ifdef SCAN_MUXER_MASK_EN
  logic [3:0]  mask4 = 4'b1111;
  logic [2:0]  mask3 = 3'b111;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  scan_muxer #(.N(4), .W(8)) u4 (
    .clock (clock), .reset (reset), .x (x4), .b (b4), .mode (mode4), .en (en4),
`ifdef SCAN_MUXER_MASK_EN
    .mask  (mask4),
`endif
    .z (z4), .ch (ch4), .valid (v4)
  );

  scan_muxer #(.N(3), .W(4)) u3 (
    .clock (clock), .reset (reset), .x (x3), .b (b3), .mode (mode3), .en (en3),
`ifdef SCAN_MUXER_MASK_EN
    .mask  (mask3),
`endif
    .z (z3), .ch (ch3), .valid (v3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [7:0] ez, input logic [1:0] ec, input logic ev);
    check({tag, ".z"},     32'(z4),  32'(ez));
    check({tag, ".ch"},    32'(ch4), 32'(ec));
    check({tag, ".valid"}, 32'(v4),  32'(ev));
  endtask

  task automatic chk3(input string tag, input logic [3:0] ez, input logic [1:0] ec, input logic ev);
    check({tag, ".z"},     32'(z3),  32'(ez));
    check({tag, ".ch"},    32'(ch3), 32'(ec));
    check({tag, ".valid"}, 32'(v3),  32'(ev));
  endtask

  initial begin
    reset = 1'b1;
    x4 = 32'hDDCC_BBAA; b4 = 2'd0; mode4 = MODE_SCAN; en4 = 1'b1;
    x3 = 12'h321;       b3 = 2'd0; mode3 = MODE_SCAN; en3 = 1'b0;

    // Reset is held while en=1.
    tick(); chk4("rst0", 8'h00, 2'd0, 1'b0);
    tick(); chk4("rst1", 8'h00, 2'd0, 1'b0);
    reset = 1'b0;

    // Scan sequence wraps from channel 3 back to 0.
    tick(); chk4("scan0", 8'hAA, 2'd0, 1'b1);
    tick(); chk4("scan1", 8'hBB, 2'd1, 1'b1);
    tick(); chk4("scan2", 8'hCC, 2'd2, 1'b1);
    tick(); chk4("scan3", 8'hDD, 2'd3, 1'b1);
    tick(); chk4("scan4", 8'hAA, 2'd0, 1'b1);
    tick(); chk4("scan5", 8'hBB, 2'd1, 1'b1);

    // With en low, changes on x do not reach z.
    en4 = 1'b0; x4 = 32'h1122_3344;
    tick(); chk4("hold", 8'hBB, 2'd1, 1'b0);
    x4 = 32'hDDCC_BBAA; en4 = 1'b1;

    // Mode switch: direct mode leaves the pointer where it was.
    reset = 1'b1;
    tick(); chk4("rst2", 8'h00, 2'd0, 1'b0);
    reset = 1'b0;
    tick(); chk4("sw_s0", 8'hAA, 2'd0, 1'b1);
    tick(); chk4("sw_s1", 8'hBB, 2'd1, 1'b1);
    mode4 = MODE_DIRECT; b4 = 2'd0;
    tick(); chk4("sw_d0", 8'hAA, 2'd0, 1'b1);
    tick(); chk4("sw_d1", 8'hAA, 2'd0, 1'b1);
    tick(); chk4("sw_d2", 8'hAA, 2'd0, 1'b1);
    mode4 = MODE_SCAN;
    tick(); chk4("sw_s2", 8'hCC, 2'd2, 1'b1);
    tick(); chk4("sw_s3", 8'hDD, 2'd3, 1'b1);

    // A reset during a scan drops the in-flight sample, and scanning restarts at channel 0.
    reset = 1'b1;
    tick(); chk4("rst_mid", 8'h00, 2'd0, 1'b0);
    reset = 1'b0;
    tick(); chk4("post_rst_scan", 8'hAA, 2'd0, 1'b1);

    // After reset, the first sample in direct mode comes from channel b.
    reset = 1'b1;
    tick(); chk4("rst3", 8'h00, 2'd0, 1'b0);
    reset = 1'b0; mode4 = MODE_DIRECT; b4 = 2'd3;
    tick(); chk4("post_rst_dir", 8'hDD, 2'd3, 1'b1);
    en4 = 1'b0;

    // N=3: the scan wraps with no out-of-range channel.
    mode3 = MODE_SCAN; en3 = 1'b1;
    tick(); chk3("n3_s0", 4'h1, 2'd0, 1'b1);
    tick(); chk3("n3_s1", 4'h2, 2'd1, 1'b1);
    tick(); chk3("n3_s2", 4'h3, 2'd2, 1'b1);
    tick(); chk3("n3_s3", 4'h1, 2'd0, 1'b1);
    mode3 = MODE_DIRECT; b3 = 2'd2;
    tick(); chk3("n3_d2", 4'h3, 2'd2, 1'b1);
    b3 = 2'd3;
    tick(); chk3("n3_d3_drop", 4'h3, 2'd2, 1'b0);
    mode3 = MODE_SCAN;
    tick(); chk3("n3_resume", 4'h2, 2'd1, 1'b1);
    en3 = 1'b0;

`ifdef SCAN_MUXER_MASK_EN
    // Masked scan: only channels 1 and 3 are enabled.
    mask4 = 4'b1010;
    reset = 1'b1;
    tick(); chk4("m_rst", 8'h00, 2'd0, 1'b0);
    reset = 1'b0; mode4 = MODE_SCAN; en4 = 1'b1;
    tick(); chk4("m_s0", 8'hBB, 2'd1, 1'b1);
    tick(); chk4("m_s1", 8'hDD, 2'd3, 1'b1);
    tick(); chk4("m_s2", 8'hBB, 2'd1, 1'b1);
    mask4 = 4'b0000;
    tick(); chk4("m_zero", 8'hBB, 2'd1, 1'b0);
    mode4 = MODE_DIRECT; b4 = 2'd0;
    tick(); chk4("m_direct", 8'hAA, 2'd0, 1'b1);
    en4 = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
